// File: rtl/sram_like_slave_responder_if.sv
// rtl/sram_like_slave_responder_if.sv - SRAM-like request/response bus plus word-memory port
// Purpose: bundles the initiator-facing req/addr_ok/data_ok signals and the
//          single-port synchronous memory port of the responder.
// Signals:
//   data_req, data_wr, data_size[1:0], data_addr[31:0],
//   data_wdata[31:0], data_wstrb[3:0]           initiator -> responder
//   data_addr_ok, data_data_ok, data_rdata[31:0] responder -> initiator
//   mem_en, mem_we[3:0], mem_addr[AW-1:0],
//   mem_wdata[31:0]                              responder -> memory
//   mem_rdata[31:0]                              memory -> responder (one cycle after mem_en)
// Modports: slave (responder), master (initiator), mem (memory).
interface sram_like_slave_responder_if #(
    parameter int AW = 10
);
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [31:0]   data_addr;
    logic [31:0]   data_wdata;
    logic [3:0]    data_wstrb;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, mem_rdata,
        output data_addr_ok, data_data_ok, data_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport mem (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sram_like_slave_responder.sv
// rtl/sram_like_slave_responder.sv - in-order SRAM-like responder in front of a synchronous word memory
// Purpose: queues read/write requests in a command FIFO and serves them one at a
//          time against the memory port, returning data_ok in acceptance order.
// Parameters: DEPTH (FIFO entries, power of two 2..16), AW (word-address width),
//             LATENCY (idle cycles before each memory access, 0..255).
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   bus            sram_like_slave_responder_if.slave (request bus + memory port)
//   stat_rd_cnt    completed reads        (only with SRAM_RESP_STATS_EN)
//   stat_wr_cnt    completed writes       (only with SRAM_RESP_STATS_EN)
//   stat_full_cnt  cycles of req while full (only with SRAM_RESP_STATS_EN)
// Optional feature macro: SRAM_RESP_STATS_EN.
module sram_like_slave_responder #(
    parameter int DEPTH   = 4,
    parameter int AW      = 10,
    parameter int LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    sram_like_slave_responder_if.slave bus
`ifdef SRAM_RESP_STATS_EN
    ,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt,
    output logic [31:0] stat_full_cnt
`endif
);
    localparam int         PW       = $clog2(DEPTH);
    localparam logic [7:0] CNT_INIT = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_RESP
    } state_t;

    cmd_t          fifo_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          full, empty, accept, pop;
    cmd_t          cmd_in, head;

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic          mem_en_q;
    logic [3:0]    mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          data_ok_q;
    logic          resp_rd_q;

    // Full/empty come from registered pointers only, so a pop in this cycle
    // cannot make room for a push in the same cycle.
    assign full   = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign accept = !rst && bus.data_req && !full;
    assign pop    = (state_q == S_ISSUE);
    assign head   = fifo_q[rd_ptr_q[PW-1:0]];

    assign cmd_in = '{
        wr:    bus.data_wr,
        size:  bus.data_size,
        addr:  bus.data_addr,
        wdata: bus.data_wdata,
        wstrb: bus.data_wstrb
    };

    assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, accept};
    assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

    // size and the non-word address bits travel with the command for
    // visibility only; nothing downstream consumes them.
    logic unused_cmd;
    assign unused_cmd = ^{head.size, head.addr[31:AW+2], head.addr[1:0]};

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Memory strobes are loaded on entry to ISSUE so they are registered and
    // line up with the ISSUE state; data_ok likewise on entry to RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            data_ok_q   <= 1'b0;
            resp_rd_q   <= 1'b0;
        end else begin
            mem_en_q  <= 1'b0;
            mem_we_q  <= 4'b0;
            data_ok_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        if (LATENCY == 0) begin
                            state_q     <= S_ISSUE;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= head.wr ? head.wstrb : 4'b0;
                            mem_addr_q  <= head.addr[AW+1:2];
                            mem_wdata_q <= head.wdata;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q     <= S_ISSUE;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= head.wr ? head.wstrb : 4'b0;
                        mem_addr_q  <= head.addr[AW+1:2];
                        mem_wdata_q <= head.wdata;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_ISSUE: begin
                    state_q   <= S_RESP;
                    data_ok_q <= 1'b1;
                    resp_rd_q <= !head.wr;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_addr_ok = accept;
    assign bus.data_data_ok = data_ok_q;
    // Memory read data lands in the RESP cycle, so it is forwarded unregistered.
    assign bus.data_rdata   = (data_ok_q && resp_rd_q) ? bus.mem_rdata : 32'd0;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;

`ifdef SRAM_RESP_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q   <= 32'd0;
            stat_wr_q   <= 32'd0;
            stat_full_q <= 32'd0;
        end else begin
            if (data_ok_q && resp_rd_q) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if (data_ok_q && !resp_rd_q) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
            if (bus.data_req && full) begin
                stat_full_q <= stat_full_q + 32'd1;
            end
        end
    end

    assign stat_rd_cnt   = stat_rd_q;
    assign stat_wr_cnt   = stat_wr_q;
    assign stat_full_cnt = stat_full_q;
`endif
endmodule

// File: tb/tb_sram_like_slave_responder.sv
// tb/tb_sram_like_slave_responder.sv - self-checking bench for sram_like_slave_responder
module tb_sram_like_slave_responder;
    localparam int NI    = 3;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int QN    = 64;

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 10);
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req   [NI];
    logic          wr    [NI];
    logic [31:0]   addr  [NI];
    logic [31:0]   wdata [NI];
    logic [3:0]    strb  [NI];
    logic          aok   [NI];
    logic          dok   [NI];
    logic [31:0]   rdat  [NI];
    logic          men   [NI];
    logic [3:0]    mwe   [NI];
    logic [AW-1:0] maddr [NI];
    logic [31:0]   mwd   [NI];
`ifdef SRAM_RESP_STATS_EN
    logic [31:0]   st_rd   [NI];
    logic [31:0]   st_wr   [NI];
    logic [31:0]   st_full [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 3 : 10);
        sram_like_slave_responder_if #(.AW(AW)) bus ();
        logic [31:0] mem [1 << AW];
        logic [31:0] rq;

        assign bus.data_req   = req[g];
        assign bus.data_wr    = wr[g];
        assign bus.data_size  = 2'b10;
        assign bus.data_addr  = addr[g];
        assign bus.data_wdata = wdata[g];
        assign bus.data_wstrb = strb[g];
        assign bus.mem_rdata  = rq;
        assign aok[g]   = bus.data_addr_ok;
        assign dok[g]   = bus.data_data_ok;
        assign rdat[g]  = bus.data_rdata;
        assign men[g]   = bus.mem_en;
        assign mwe[g]   = bus.mem_we;
        assign maddr[g] = bus.mem_addr;
        assign mwd[g]   = bus.mem_wdata;

        initial begin
            for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
            rq = 32'd0;
        end

        always @(posedge clk) begin
            if (bus.mem_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                rq <= mem[bus.mem_addr];
            end
        end

        sram_like_slave_responder #(.DEPTH(DEPTH), .AW(AW), .LATENCY(L)) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
`ifdef SRAM_RESP_STATS_EN
            ,
            .stat_rd_cnt(st_rd[g]),
            .stat_wr_cnt(st_wr[g]),
            .stat_full_cnt(st_full[g])
`endif
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: pending commands with their scheduled data_ok cycle.
    logic          q_wr    [NI][QN];
    logic [31:0]   q_addr  [NI][QN];
    logic [31:0]   q_wdata [NI][QN];
    logic [3:0]    q_strb  [NI][QN];
    int            q_cyc   [NI][QN];
    int            q_hd    [NI];
    int            q_tl    [NI];
    int            last_sched [NI];
    logic [31:0]   mmem    [NI][1 << AW];
    int            n_rd [NI];
    int            n_wr [NI];
    int            n_full [NI];

    logic          smp_aok [NI];
    logic          smp_dok [NI];
    logic [31:0]   smp_rdat[NI];
    logic          smp_men [NI];
    logic [3:0]    smp_mwe [NI];
    logic [AW-1:0] smp_maddr[NI];
    logic [31:0]   smp_mwd [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        int occ, idx, l, nxt;
        logic [AW-1:0] w;
        logic [31:0] ev;
        for (int k = 0; k < NI; k++) begin
            smp_aok[k] = aok[k];   smp_dok[k] = dok[k];   smp_rdat[k] = rdat[k];
            smp_men[k] = men[k];   smp_mwe[k] = mwe[k];   smp_maddr[k] = maddr[k];
            smp_mwd[k] = mwd[k];
            l = lat_of(k);
            if (rst) begin
                chk("reset_addr_ok", 32'(aok[k]), 32'd0);
                chk("reset_data_ok", 32'(dok[k]), 32'd0);
                chk("reset_rdata", rdat[k], 32'd0);
                chk("reset_mem_en", 32'(men[k]), 32'd0);
                chk("reset_mem_we", 32'(mwe[k]), 32'd0);
                q_hd[k] = q_tl[k];
                last_sched[k] = -1000;
                n_rd[k] = 0; n_wr[k] = 0; n_full[k] = 0;
            end else begin
                if (dok[k]) begin
                    if (q_hd[k] == q_tl[k]) begin
                        chk("spurious_data_ok", 32'(dok[k]), 32'd0);
                    end else begin
                        idx = q_hd[k] % QN;
                        chk("data_ok_cycle", 32'(cyc), 32'(q_cyc[k][idx]));
                        w = q_addr[k][idx][AW+1:2];
                        if (q_wr[k][idx]) begin
                            for (int b = 0; b < 4; b++)
                                if (q_strb[k][idx][b]) mmem[k][w][8*b +: 8] = q_wdata[k][idx][8*b +: 8];
                            ev = 32'd0;
                            n_wr[k]++;
                        end else begin
                            ev = mmem[k][w];
                            n_rd[k]++;
                        end
                        chk("data_rdata", rdat[k], ev);
                        q_hd[k]++;
                    end
                end else begin
                    chk("rdata_idle_zero", rdat[k], 32'd0);
                    if (q_hd[k] != q_tl[k] && q_cyc[k][q_hd[k] % QN] == cyc)
                        chk("missing_data_ok", 32'(dok[k]), 32'd1);
                end
                // A command holds its slot until the cycle it is answered.
                occ = 0;
                for (int j = q_hd[k]; j < q_tl[k]; j++)
                    if (q_cyc[k][j % QN] > cyc) occ++;
                chk("addr_ok", 32'(aok[k]), 32'(req[k] && (occ < DEPTH)));
                if (req[k] && occ >= DEPTH) n_full[k]++;
                if (req[k] && aok[k]) begin
                    idx = q_tl[k] % QN;
                    q_wr[k][idx] = wr[k];    q_addr[k][idx] = addr[k];
                    q_wdata[k][idx] = wdata[k]; q_strb[k][idx] = strb[k];
                    nxt = cyc + 3 + l;
                    if (last_sched[k] + 3 + l > nxt) nxt = last_sched[k] + 3 + l;
                    q_cyc[k][idx] = nxt;
                    last_sched[k] = nxt;
                    q_tl[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; strb[k] = s;
        for (int n = 0; n < 300 && !ok; n++) begin
            tick();
            if (smp_aok[k]) begin
                ok = 1'b1;
                acc = cyc - 1;
            end
        end
        req[k] = 1'b0;
        chk("req_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_ok(input int k, output logic [31:0] rd, output int c);
        bit ok;
        ok = 1'b0;
        rd = 32'd0;
        c = -1;
        for (int n = 0; n < 300 && !ok; n++) begin
            tick();
            if (smp_dok[k]) begin
                ok = 1'b1;
                rd = smp_rdat[k];
                c = cyc - 1;
            end
        end
        chk("data_ok_seen", 32'(ok), 32'd1);
    endtask

    task automatic drain(input int k);
        for (int n = 0; n < 2000 && q_hd[k] != q_tl[k]; n++) tick();
        chk("drained", 32'(q_tl[k] - q_hd[k]), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int acc, c, c1, c2, base;
        int accs [6];
        logic [31:0] rd;

        vt[0] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
        vt[1] = '{1'b1, 32'h11, 32'h0000AA00, 4'h2, 32'h0};
        vt[2] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADAAEF};
        vt[3] = '{1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0};
        vt[4] = '{1'b1, 32'h22, 32'hAABB0000, 4'hC, 32'h0};
        vt[5] = '{1'b0, 32'h20, 32'h0,        4'h0, 32'hAABB5678};
        vt[6] = '{1'b1, 32'h24, 32'h000000FF, 4'h1, 32'h0};
        vt[7] = '{1'b0, 32'h27, 32'h0,        4'h0, 32'h000000FF};

        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; strb[k] = 4'd0;
            q_hd[k] = 0; q_tl[k] = 0; last_sched[k] = -1000;
            n_rd[k] = 0; n_wr[k] = 0; n_full[k] = 0;
            for (int i = 0; i < (1 << AW); i++) mmem[k][i] = 32'd0;
        end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // LATENCY=0 full write: memory strobe at T+2, data_ok at T+3.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
        tick();
        chk("wr_mem_en_t1", 32'(smp_men[0]), 32'd0);
        tick();
        chk("wr_mem_en_t2", 32'(smp_men[0]), 32'd1);
        chk("wr_mem_we_t2", 32'(smp_mwe[0]), 32'hF);
        chk("wr_mem_addr_t2", 32'(smp_maddr[0]), 32'd4);
        chk("wr_mem_wdata_t2", smp_mwd[0], 32'hDEADBEEF);
        chk("wr_data_ok_t2", 32'(smp_dok[0]), 32'd0);
        tick();
        chk("wr_data_ok_t3", 32'(smp_dok[0]), 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_req(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, acc);
            wait_ok(0, rd, c);
            chk("vec_latency", 32'(c), 32'(acc + 3));
            chk("vec_rdata", rd, vt[i].exp);
        end

        // LATENCY=3: preload words 1..3, then back-to-back reads.
        for (int i = 1; i <= 3; i++) begin
            do_req(1, 1'b1, 32'(4 * i), 32'(i), 4'hF, acc);
            drain(1);
        end
        for (int i = 1; i <= 3; i++) do_req(1, 1'b0, 32'(4 * i), 32'd0, 4'h0, accs[i-1]);
        wait_ok(1, rd, c1);
        chk("lat3_first_latency", 32'(c1), 32'(accs[0] + 6));
        chk("lat3_rdata1", rd, 32'd1);
        wait_ok(1, rd, c2);
        chk("lat3_spacing12", 32'(c2 - c1), 32'd6);
        chk("lat3_rdata2", rd, 32'd2);
        wait_ok(1, rd, c);
        chk("lat3_spacing23", 32'(c - c2), 32'd6);
        chk("lat3_rdata3", rd, 32'd3);

        // LATENCY=10, DEPTH=4: six writes with data_req held.
        base = n_wr[2];
        for (int i = 0; i < 6; i++) do_req(2, 1'b1, 32'(32'h100 + 4 * i), 32'(i + 100), 4'hF, accs[i]);
        for (int i = 1; i < 4; i++) chk("full_consecutive_accept", 32'(accs[i]), 32'(accs[0] + i));
        chk("full_fifth_accept", 32'(accs[4]), 32'(accs[0] + 13));
        chk("full_sixth_accept", 32'(accs[5]), 32'(accs[0] + 26));
        drain(2);
        chk("full_data_ok_total", 32'(n_wr[2] - base), 32'd6);

        // Reset while the first of three queued commands sits in WAIT.
        for (int i = 0; i < 3; i++) do_req(2, 1'b1, 32'(32'h200 + 4 * i), 32'h11111111, 4'hF, acc);
        tick();
        tick();
        rst = 1'b1;
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h0;
        #1;
        chk("async_rst_addr_ok", 32'(aok[2]), 32'd0);
        chk("async_rst_data_ok", 32'(dok[2]), 32'd0);
        chk("async_rst_rdata", rdat[2], 32'd0);
        chk("async_rst_mem_en", 32'(men[2]), 32'd0);
        chk("async_rst_mem_we", 32'(mwe[2]), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        req[2] = 1'b0;
        repeat (30) tick();
        do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, acc);
        wait_ok(0, rd, c);
        chk("post_rst_latency0", 32'(c), 32'(acc + 3));
        do_req(2, 1'b0, 32'h200, 32'd0, 4'h0, acc);
        wait_ok(2, rd, c);
        chk("post_rst_latency10", 32'(c), 32'(acc + 13));
        chk("post_rst_dropped_write", rd, 32'd0);

        // Five reads and two writes on a freshly reset instance.
        do_req(1, 1'b1, 32'h30, 32'hCAFE0001, 4'hF, acc);
        do_req(1, 1'b1, 32'h34, 32'hCAFE0002, 4'hF, acc);
        for (int i = 0; i < 5; i++) do_req(1, 1'b0, 32'(32'h30 + 4 * (i % 2)), 32'd0, 4'h0, acc);
        drain(1);
`ifdef SRAM_RESP_STATS_EN
        chk("stat_rd_five", st_rd[1], 32'd5);
        chk("stat_wr_two", st_wr[1], 32'd2);
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 25; i++) begin
                do_req(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                       4'($urandom_range(0, 15)), acc);
                repeat ($urandom_range(0, 3)) tick();
            end
            drain(k);
        end

`ifdef SRAM_RESP_STATS_EN
        for (int k = 0; k < NI; k++) begin
            chk("stat_rd_cnt", st_rd[k], 32'(n_rd[k]));
            chk("stat_wr_cnt", st_wr[k], 32'(n_wr[k]));
            chk("stat_full_cnt", st_full[k], 32'(n_full[k]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
